// File: rtl/fde_pkg.sv
// Shared constants, opcodes, FSM states and the constant program image
// for the FDE accumulator CPU.
package fde_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int OP_W   = DATA_W - ADDR_W;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
  localparam logic [OP_W-1:0] OP_LDA  = 4'h2;
  localparam logic [OP_W-1:0] OP_STA  = 4'h3;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h4;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h5;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h6;
  localparam logic [OP_W-1:0] OP_AND  = 4'h7;
  localparam logic [OP_W-1:0] OP_OR   = 4'h8;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h9;
  localparam logic [OP_W-1:0] OP_JMP  = 4'hA;
  localparam logic [OP_W-1:0] OP_JZ   = 4'hB;
  localparam logic [OP_W-1:0] OP_HLT  = 4'hF;

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE} state_t;

  function automatic logic [DATA_W-1:0] rom_image(input logic [ADDR_W-1:0] a);
    case (a)
      4'd0:    return 8'h15;
      4'd1:    return 8'h30;
      4'd2:    return 8'h63;
      4'd3:    return 8'h31;
      4'd4:    return 8'h40;
      4'd5:    return 8'h32;
      4'd6:    return 8'h51;
      4'd7:    return 8'h33;
      4'd8:    return 8'hF0;
      default: return 8'h00;
    endcase
  endfunction

  // Opcodes that load the accumulator and therefore also refresh Z.
  function automatic logic writes_acc(input logic [OP_W-1:0] op);
    return (op >= OP_LDI) && (op <= OP_XOR) && (op != OP_STA);
  endfunction

endpackage

// File: rtl/fde_alu.sv
// Combinational accumulator datapath; passes ACC through for non-ALU opcodes.
module fde_alu
  import fde_pkg::*;
(
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  input  logic [ADDR_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  logic [DATA_W-1:0] imm_ext;
  assign imm_ext = {{OP_W{1'b0}}, imm};

  always_comb begin
    result = acc;
    case (opcode)
      OP_LDI:  result = imm_ext;
      OP_LDA:  result = operand;
      OP_ADD:  result = acc + operand;
      OP_SUB:  result = acc - operand;
      OP_ADDI: result = acc + imm_ext;
      OP_AND:  result = acc & operand;
      OP_OR:   result = acc | operand;
      OP_XOR:  result = acc ^ operand;
      default: result = acc;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/fde_cpu.sv
// 8-bit accumulator CPU: 3-phase fetch/decode/execute sequencer with an
// internal program ROM and data RAM; exposes only the last store.
module fde_cpu
  import fde_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_stop,
  output logic [ADDR_W-1:0] o_write_add,
  output logic [DATA_W-1:0] o_write_data
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] acc;
  logic              z;
  logic              halted;
  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] opnd_data;
  logic [DATA_W-1:0] ram [2**ADDR_W];

  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  fde_alu u_alu (
    .opcode  (opcode),
    .acc     (acc),
    .operand (opnd_data),
    .imm     (operand),
    .result  (alu_result),
    .zero    (alu_zero)
  );

  // Halted machine parks in FETCH until reset.
  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:   if (!halted) state_n = S_DECODE;
      S_DECODE:  state_n = S_EXECUTE;
      S_EXECUTE: state_n = S_FETCH;
      default:   state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= S_FETCH;
      pc           <= '0;
      ir           <= '0;
      acc          <= '0;
      z            <= 1'b1;
      halted       <= 1'b0;
      opcode       <= OP_NOP;
      operand      <= '0;
      opnd_data    <= '0;
      o_write_add  <= '0;
      o_write_data <= '0;
      for (int i = 0; i < 2**ADDR_W; i++) ram[i] <= '0;
    end else if (!i_stop) begin
      state <= state_n;
      case (state)
        S_FETCH: if (!halted) begin
          ir <= rom_image(pc);
          pc <= pc + 1'b1;
        end
        S_DECODE: begin
          opcode    <= ir[DATA_W-1:ADDR_W];
          operand   <= ir[ADDR_W-1:0];
          opnd_data <= ram[ir[ADDR_W-1:0]];
        end
        S_EXECUTE: begin
          if (writes_acc(opcode)) begin
            acc <= alu_result;
            z   <= alu_zero;
          end
          case (opcode)
            OP_STA: begin
              ram[operand] <= acc;
              o_write_add  <= operand;
              o_write_data <= acc;
            end
            OP_JMP:  pc <= operand;
            OP_JZ:   if (z) pc <= operand;
            OP_HLT:  halted <= 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fde_cpu.sv
// Scoreboard bench: an instruction-level interpreter predicts every store and
// the active edge it lands on; a monitor matches each output change in order.
module tb_fde_cpu;

  logic       i_clk   = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_stop  = 1'b0;
  logic [3:0] o_write_add;
  logic [7:0] o_write_data;

  fde_cpu dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_stop       (i_stop),
    .o_write_add  (o_write_add),
    .o_write_data (o_write_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int edge_n;
    int addr;
    int data;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errs    = 0;

  logic [7:0] rom [16] = '{8'h15, 8'h30, 8'h63, 8'h31, 8'h40, 8'h32, 8'h51, 8'h33,
                           8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Interpret the program from reset; instruction t completes on active edge 3*t.
  task automatic gen_expect();
    int pc, acc, z, op, a;
    int ram [16];
    logic [7:0] ins;
    sb.delete();
    pc = 0; acc = 0; z = 1;
    foreach (ram[i]) ram[i] = 0;
    for (int t = 1; t <= 48; t++) begin
      ins = rom[pc];
      pc  = (pc + 1) % 16;
      op  = int'(ins[7:4]);
      a   = int'(ins[3:0]);
      if (op == 15) break;
      case (op)
        1: acc = a;
        2: acc = ram[a];
        3: begin
          ram[a] = acc;
          sb.push_back('{3 * t, a, acc});
        end
        4: acc = (acc + ram[a]) % 256;
        5: acc = (acc - ram[a] + 256) % 256;
        6: acc = (acc + a) % 256;
        7: acc = acc & ram[a];
        8: acc = acc | ram[a];
        9: acc = acc ^ ram[a];
        10: pc = a;
        11: if (z != 0) pc = a;
        default: ;
      endcase
      if (op >= 1 && op <= 9 && op != 3) z = (acc == 0) ? 1 : 0;
    end
  endtask

  // Monitor: counts unstalled, non-reset edges since the last reset.
  int   m_act = 0;
  int   m_pa  = 0;
  int   m_pd  = 0;
  logic m_r, m_s;
  exp_t m_e;

  initial begin
    forever begin
      @(posedge i_clk);
      m_r = i_reset;
      m_s = i_stop;
      #1;
      if (m_r) begin
        m_act = 0;
        check("reset_add", int'(o_write_add), 0);
        check("reset_data", int'(o_write_data), 0);
        check("reset_pc", int'(dut.pc), 0);
        m_pa = 0;
        m_pd = 0;
      end else begin
        if (!m_s) m_act++;
        if (int'(o_write_add) != m_pa || int'(o_write_data) != m_pd) begin
          if (sb.size() == 0) begin
            check("spurious_store_add", int'(o_write_add), m_pa);
            check("spurious_store_data", int'(o_write_data), m_pd);
          end else begin
            m_e = sb.pop_front();
            check("store_add", int'(o_write_add), m_e.addr);
            check("store_data", int'(o_write_data), m_e.data);
            check("store_edge", m_act, m_e.edge_n);
          end
          m_pa = int'(o_write_add);
          m_pd = int'(o_write_data);
        end
      end
    end
  end

  task automatic run_active(input int n, input int stall_pct);
    int k = 0;
    while (k < n) begin
      @(negedge i_clk);
      i_reset = 1'b0;
      i_stop  = ($urandom_range(99) < stall_pct);
      if (!i_stop) k++;
    end
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      @(negedge i_clk);
      i_reset = 1'b0;
      i_stop  = 1'b1;
    end
  endtask

  task automatic do_reset(input bit with_stop);
    @(negedge i_clk);
    i_reset = 1'b1;
    i_stop  = with_stop;
    gen_expect();
  endtask

  initial begin
    gen_expect();
    @(negedge i_clk);
    // Stall straight out of reset, then run through HLT and well beyond.
    stall(10);
    run_active(27, 0);
    run_active(100, 0);
    check("halt_pc", int'(dut.pc), 9);
    check("drain_halt", sb.size(), 0);

    // Two-cycle stall between active edges 3 and 4.
    do_reset(0);
    run_active(3, 0);
    stall(2);
    run_active(30, 0);
    check("drain_stall2", sb.size(), 0);

    // Reset during DECODE of the instruction at address 3.
    do_reset(0);
    run_active(10, 0);
    do_reset(0);
    run_active(30, 0);
    check("drain_mid_reset", sb.size(), 0);

    // Reset coincident with stall.
    do_reset(0);
    run_active(7, 0);
    do_reset(1);
    run_active(30, 0);
    check("drain_reset_stop", sb.size(), 0);

    // Random stalls and random reset points.
    for (int it = 0; it < 8; it++) begin
      do_reset(bit'($urandom_range(1)));
      run_active(int'($urandom_range(1, 26)), 35);
    end
    do_reset(0);
    run_active(30, 35);
    check("drain_random", sb.size(), 0);

    @(negedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
